// File: rtl/simplerisc_pkg.sv
// Shared SimpleRISC pipeline types and widths.
package simplerisc_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } dm_state_t;

endpackage

// File: rtl/dm_timeout_ctr.sv
// Cycle counter that bounds how long a memory access may stay outstanding.
module dm_timeout_ctr #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = enable && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/dm_mem_stage.sv
// SimpleRISC DM stage: issues ld/st to data memory and stalls the pipe until done.
module dm_mem_stage
  import simplerisc_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_DM,
  input  logic                  isLd_DM,
  input  logic                  isSt_DM,
  input  logic [DATA_W-1:0]     aluResult_DM,
  input  logic [DATA_W-1:0]     op2_DM,
  input  logic [REG_ADDR_W-1:0] rd_DM,
  input  logic                  isWb_DM,
  output logic [DATA_W-1:0]     DMResult_DM,
  output logic                  isWbOut_DM,
  output logic [REG_ADDR_W-1:0] rdOut_DM,
  output logic [DATA_W-1:0]     aluResultOut_DM,
  output logic                  stall_DM,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  mem_err
);

  dm_state_t state, next_state;
  logic      mem_op, busy, expired;
  logic      capture_rdata, abort_access;

  assign mem_op = valid_DM & (isLd_DM | isSt_DM);
  assign busy   = (state == REQ) || (state == WAIT);

  dm_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (!busy),
    .enable  (busy),
    .expired (expired)
  );

  // A grant or read response in the expiring cycle wins over the abort.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    next_state    = state;
    capture_rdata = 1'b0;
    abort_access  = 1'b0;
    unique case (state)
      IDLE: if (mem_op) next_state = REQ;
      REQ: begin
        if (mem_gnt) begin
          if (mem_we) begin
            next_state = DONE;
          end else if (mem_rvalid) begin
            capture_rdata = 1'b1;
            next_state    = DONE;
          end else begin
            next_state = WAIT;
          end
        end else if (expired) begin
          abort_access = 1'b1;
          next_state   = DONE;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          capture_rdata = 1'b1;
          next_state    = DONE;
        end else if (expired) begin
          abort_access = 1'b1;
          next_state   = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      DMResult_DM <= '0;
      mem_err     <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && mem_op) begin
        mem_addr  <= aluResult_DM[ADDR_W+1:2];
        mem_wdata <= op2_DM;
        mem_we    <= isSt_DM;
      end
      if (capture_rdata) begin
        DMResult_DM <= mem_rdata;
      end else if (abort_access) begin
        DMResult_DM <= '0;
        mem_err     <= 1'b1;
      end
    end
  end

  // Gated by rst so the pipe unfreezes immediately even while a memory op sits in EX/DM.
  assign mem_req  = !rst && (state == REQ);
  assign stall_DM = !rst && (busy || (state == IDLE && mem_op));

  assign isWbOut_DM      = isWb_DM & ~stall_DM;
  assign rdOut_DM        = rd_DM;
  assign aluResultOut_DM = aluResult_DM;

endmodule

// File: tb/tb_dm_mem_stage.sv
// Directed self-checking bench for dm_mem_stage (TIMEOUT shortened to 8).
module tb_dm_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_DM, isLd_DM, isSt_DM, isWb_DM;
  logic [31:0] aluResult_DM, op2_DM;
  logic [4:0]  rd_DM;
  logic [31:0] DMResult_DM, aluResultOut_DM, mem_wdata, mem_rdata;
  logic        isWbOut_DM, stall_DM, mem_req, mem_we, mem_gnt, mem_rvalid, mem_err;
  logic [4:0]  rdOut_DM;
  logic [15:0] mem_addr;

  int checks = 0;
  int errors = 0;

  dm_mem_stage #(.ADDR_W(16), .TIMEOUT(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .valid_DM        (valid_DM),
    .isLd_DM         (isLd_DM),
    .isSt_DM         (isSt_DM),
    .aluResult_DM    (aluResult_DM),
    .op2_DM          (op2_DM),
    .rd_DM           (rd_DM),
    .isWb_DM         (isWb_DM),
    .DMResult_DM     (DMResult_DM),
    .isWbOut_DM      (isWbOut_DM),
    .rdOut_DM        (rdOut_DM),
    .aluResultOut_DM (aluResultOut_DM),
    .stall_DM        (stall_DM),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_gnt         (mem_gnt),
    .mem_rvalid      (mem_rvalid),
    .mem_rdata       (mem_rdata),
    .mem_err         (mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, is_ld, is_st, is_wb;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        exp_stall, exp_wb;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic v, ld, st, wb, input logic [31:0] alu, op2,
                           input logic [4:0] rd);
    valid_DM = v; isLd_DM = ld; isSt_DM = st; isWb_DM = wb;
    aluResult_DM = alu; op2_DM = op2; rd_DM = rd;
  endtask

  task automatic set_mem(input logic gnt, rv, input logic [31:0] rdata);
    mem_gnt = gnt; mem_rvalid = rv; mem_rdata = rdata;
  endtask

  task automatic nop();
    set_instr(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    set_mem(1'b0, 1'b0, 32'h0);
  endtask

  // ld answered with gnt+rvalid in its first REQ cycle: IDLE -> REQ -> DONE.
  task automatic zero_wait_ld(input logic [31:0] alu, input logic [15:0] exp_addr,
                              input logic [31:0] rdata, input logic exp_err);
    set_instr(1'b1, 1'b1, 1'b0, 1'b1, alu, 32'h0, 5'd9);
    set_mem(1'b0, 1'b0, 32'h0);
    #1;
    check("zw_c0_stall", stall_DM, 1);
    step();
    set_mem(1'b1, 1'b1, rdata);
    #1;
    check("zw_c1_req", mem_req, 1);
    check("zw_c1_addr", mem_addr, exp_addr);
    check("zw_c1_wbout", isWbOut_DM, 0);
    step();
    set_mem(1'b0, 1'b0, 32'h0);
    #1;
    check("zw_c2_stall", stall_DM, 0);
    check("zw_c2_wbout", isWbOut_DM, 1);
    check("zw_c2_result", DMResult_DM, rdata);
    check("zw_c2_err", mem_err, exp_err);
    step();
    nop();
    #1;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_1234, 5'd5,  1'b0, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 5'd31, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0040, 5'd3,  1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0008, 5'd17, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_0001, 5'd0,  1'b0, 1'b1};

    rst = 1'b1;
    nop();
    #2;
    check("rst_stall", stall_DM, 0);
    check("rst_req", mem_req, 0);
    check("rst_result", DMResult_DM, 32'h0);
    check("rst_err", mem_err, 0);
    check("rst_addr", mem_addr, 16'h0);
    #10 rst = 1'b0;
    step();

    // Non-memory and bubble instructions pass straight through.
    for (int i = 0; i < 5; i++) begin
      set_instr(vecs[i].valid, vecs[i].is_ld, vecs[i].is_st, vecs[i].is_wb,
                vecs[i].alu, 32'h0, vecs[i].rd);
      #1;
      check("vec_stall", stall_DM, vecs[i].exp_stall);
      check("vec_wbout", isWbOut_DM, vecs[i].exp_wb);
      check("vec_rd", rdOut_DM, vecs[i].rd);
      check("vec_alu", aluResultOut_DM, vecs[i].alu);
      check("vec_req", mem_req, 0);
      step();
    end
    nop();

    // ld 0x40: gnt in cycle 1, rvalid in cycle 3, DONE in cycle 4.
    set_instr(1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 5'd7);
    #1;
    check("ld_c0_stall", stall_DM, 1);
    check("ld_c0_wbout", isWbOut_DM, 0);
    check("ld_c0_req", mem_req, 0);
    step();
    set_mem(1'b1, 1'b0, 32'h0);
    #1;
    check("ld_c1_req", mem_req, 1);
    check("ld_c1_addr", mem_addr, 16'h0010);
    check("ld_c1_we", mem_we, 0);
    check("ld_c1_stall", stall_DM, 1);
    step();
    set_mem(1'b0, 1'b0, 32'h0);
    #1;
    check("ld_c2_req", mem_req, 0);
    check("ld_c2_stall", stall_DM, 1);
    step();
    set_mem(1'b0, 1'b1, 32'hDEAD_BEEF);
    #1;
    check("ld_c3_stall", stall_DM, 1);
    check("ld_c3_wbout", isWbOut_DM, 0);
    step();
    set_mem(1'b0, 1'b0, 32'h0);
    #1;
    check("ld_c4_stall", stall_DM, 0);
    check("ld_c4_wbout", isWbOut_DM, 1);
    check("ld_c4_result", DMResult_DM, 32'hDEAD_BEEF);
    step();
    nop();

    // st 0xCAFEF00D to 0x08 with gnt withheld for 5 REQ cycles.
    set_instr(1'b1, 1'b0, 1'b1, 1'b0, 32'h8, 32'hCAFE_F00D, 5'd0);
    #1;
    check("st_c0_stall", stall_DM, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      set_mem(1'b0, 1'b0, 32'h0);
      #1;
      check("st_hold_req", mem_req, 1);
      check("st_hold_we", mem_we, 1);
      check("st_hold_addr", mem_addr, 16'h0002);
      check("st_hold_wdata", mem_wdata, 32'hCAFE_F00D);
      check("st_hold_stall", stall_DM, 1);
    end
    step();
    set_mem(1'b1, 1'b0, 32'h0);
    #1;
    check("st_gnt_req", mem_req, 1);
    check("st_gnt_stall", stall_DM, 1);
    step();
    set_mem(1'b0, 1'b0, 32'h0);
    #1;
    check("st_done_stall", stall_DM, 0);
    check("st_done_req", mem_req, 0);
    step();
    nop();

    // Zero-wait ld; upper and low address bits must be dropped.
    zero_wait_ld(32'hABC4_0043, 16'h0010, 32'h0000_0055, 1'b0);

    // Completion in the expiring 8th REQ cycle wins over the timeout.
    set_instr(1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 5'd4);
    #1;
    for (int i = 1; i <= 7; i++) begin
      step();
      set_mem(1'b0, 1'b0, 32'h0);
      #1;
      check("pri_req", mem_req, 1);
    end
    step();
    set_mem(1'b1, 1'b1, 32'h0000_0099);
    #1;
    step();
    set_mem(1'b0, 1'b0, 32'h0);
    #1;
    check("pri_done_stall", stall_DM, 0);
    check("pri_result", DMResult_DM, 32'h0000_0099);
    check("pri_err", mem_err, 0);
    step();
    nop();

    // Silent memory: abort after 8 REQ cycles.
    set_instr(1'b1, 1'b1, 1'b0, 1'b1, 32'h200, 32'h0, 5'd6);
    #1;
    for (int i = 1; i <= 8; i++) begin
      step();
      set_mem(1'b0, 1'b0, 32'h0);
      #1;
      check("to_req", mem_req, 1);
      check("to_err_low", mem_err, 0);
      check("to_stall", stall_DM, 1);
    end
    step();
    #1;
    check("to_done_stall", stall_DM, 0);
    check("to_err", mem_err, 1);
    check("to_result", DMResult_DM, 32'h0);
    step();
    nop();
    #1;
    check("to_after_stall", stall_DM, 0);
    check("to_after_err", mem_err, 1);
    step();

    zero_wait_ld(32'h0000_0010, 16'h0004, 32'h0000_A5A5, 1'b1);

    // Reset while in WAIT abandons the access immediately.
    set_instr(1'b1, 1'b1, 1'b0, 1'b1, 32'h44, 32'h0, 5'd2);
    #1;
    step();
    set_mem(1'b1, 1'b0, 32'h0);
    #1;
    step();
    set_mem(1'b0, 1'b0, 32'h0);
    #1;
    check("rw_wait_stall", stall_DM, 1);
    check("rw_wait_req", mem_req, 0);
    rst = 1'b1;
    #1;
    check("rw_rst_stall", stall_DM, 0);
    check("rw_rst_req", mem_req, 0);
    check("rw_rst_err", mem_err, 0);
    check("rw_rst_result", DMResult_DM, 32'h0);
    nop();
    step();
    step();
    rst = 1'b0;
    #1;
    check("rw_idle_stall", stall_DM, 0);
    zero_wait_ld(32'h0000_0080, 16'h0020, 32'h1234_5678, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
